// File: rtl/sha3_rho_pipe_if.sv
// sha3_rho_pipe_if: valid/ready stream interface around the Keccak rho stage.
// Carries one 25-lane state beat plus its inverse flag on each side.
//   in_state/in_inv/in_valid/in_ready     upstream (theta side) handshake
//   out_state/out_inv/out_valid/out_ready downstream (pi side) handshake
// master = the environment driving beats in and draining them out;
// slave  = the rho pipeline itself.
`timescale 1ns/1ps
interface sha3_rho_pipe_if #(
   parameter int unsigned LANE_W = 64
);
   localparam int unsigned STATE_W = 25 * LANE_W;

   logic [STATE_W-1:0] in_state;
   logic               in_inv;
   logic               in_valid;
   logic               in_ready;
   logic [STATE_W-1:0] out_state;
   logic               out_inv;
   logic               out_valid;
   logic               out_ready;

   modport master (
      output in_state, in_inv, in_valid, out_ready,
      input  in_ready, out_state, out_inv, out_valid
   );

   modport slave (
      input  in_state, in_inv, in_valid, out_ready,
      output in_ready, out_state, out_inv, out_valid
   );
endinterface

// File: rtl/sha3_rho_pipe.sv
// sha3_rho_pipe: Keccak-f rho step with a DEPTH-stage elastic pipeline.
// Each lane (x,y) is rotated by its fixed rho offset mod LANE_W (left, or
// right when the beat's inv flag is set); the rotated beat enters stage 0
// and walks through DEPTH register stages with valid/ready backpressure.
//   clk  clock
//   rst  synchronous active-high reset, clears every stage
//   bus  sha3_rho_pipe_if.slave: in_* beat in, out_* beat out
`timescale 1ns/1ps
module sha3_rho_pipe #(
   parameter int unsigned LANE_W = 64,
   parameter int unsigned DEPTH  = 1
) (
   input logic            clk,
   input logic            rst,
   sha3_rho_pipe_if.slave bus
);
   localparam int unsigned STATE_W = 25 * LANE_W;

   // Rho offsets indexed by lane number x + 5*y.
   localparam int unsigned RHO_OFF [25] = '{
       0,  1, 62, 28, 27,
      36, 44,  6, 55, 20,
       3, 10, 43, 25, 39,
      41, 45, 15, 21,  8,
      18,  2, 61, 56, 14
   };

   if (!(LANE_W == 8 || LANE_W == 16 || LANE_W == 32 || LANE_W == 64)) begin : g_bad_lane_w
      $error("sha3_rho_pipe: LANE_W must be 8, 16, 32 or 64");
   end
   if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("sha3_rho_pipe: DEPTH must be 1..4");
   end

   // Fixed-offset rotation per lane; direction picked by in_inv.
   logic [STATE_W-1:0] rot_state;

   for (genvar i = 0; i < 25; i++) begin : g_lane
      localparam int unsigned OFF = RHO_OFF[i] % LANE_W;
      logic [LANE_W-1:0] lane;
      assign lane = bus.in_state[i*LANE_W +: LANE_W];
      if (OFF == 0) begin : g_pass
         assign rot_state[i*LANE_W +: LANE_W] = lane;
      end else begin : g_rot
         assign rot_state[i*LANE_W +: LANE_W] = bus.in_inv
            ? {lane[OFF-1:0], lane[LANE_W-1:OFF]}
            : {lane[LANE_W-OFF-1:0], lane[LANE_W-1:LANE_W-OFF]};
      end
   end

   logic [STATE_W-1:0] data_q  [DEPTH];
   logic [DEPTH-1:0]   inv_q;
   logic [DEPTH-1:0]   v_q;
   logic [DEPTH-1:0]   rdy;
   logic [STATE_W-1:0] up_data [DEPTH];
   logic [DEPTH-1:0]   up_inv;
   logic [DEPTH-1:0]   up_v;

   // What each stage would load: the rotated input for stage 0, the previous stage otherwise.
   always_comb begin
      up_data[0] = rot_state;
      up_inv[0]  = bus.in_inv;
      up_v[0]    = bus.in_valid;
      for (int k = 1; k < int'(DEPTH); k++) begin
         up_data[k] = data_q[k-1];
         up_inv[k]  = inv_q[k-1];
         up_v[k]    = v_q[k-1];
      end
   end

   // A stage is ready when it is empty or everything downstream of it can move,
   // so bubbles anywhere in the pipe are squeezed out in a single cycle.
   always_comb begin
      logic acc;
      acc = bus.out_ready;
      rdy = '0;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         acc    = acc | ~v_q[k];
         rdy[k] = acc;
      end
   end

   // Stage registers; payload only loads for a valid upstream beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q   <= '0;
         inv_q <= '0;
         for (int k = 0; k < int'(DEPTH); k++) begin
            data_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            if (rdy[k]) begin
               v_q[k] <= up_v[k];
               if (up_v[k]) begin
                  data_q[k] <= up_data[k];
                  inv_q[k]  <= up_inv[k];
               end
            end
         end
      end
   end

   assign bus.in_ready  = rdy[0];
   assign bus.out_state = data_q[DEPTH-1];
   assign bus.out_inv   = inv_q[DEPTH-1];
   assign bus.out_valid = v_q[DEPTH-1];

endmodule

// File: doc/sha3_rho_pipe.md
Name: sha3_rho_pipe

Overview:
- Parametrised Keccak-f rho step, the successor to the fixed 64-bit pass-through rho stage.
- Rotates each of the 25 lanes by its standard rho offset, taken modulo LANE_W.
- Supports lane widths 8/16/32/64, a selectable inverse (rotate-right) mode, and a DEPTH-stage elastic pipeline with valid/ready backpressure.
- Sits between theta and pi in the permutation round datapath.

Parameters:
- LANE_W, 64, lane width in bits; legal values 8, 16, 32, 64 (elaboration error otherwise).
- DEPTH, 1, number of register stages, 1..4 (elaboration error otherwise); rotation is applied before stage 0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_state  in  25*LANE_W  input state; lane (x,y) at bits [(x+5*y)*LANE_W +: LANE_W].
- in_inv  in  1  1 = inverse rho (rotate right); sampled with in_state and carried along with that beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- out_state  out  25*LANE_W  rotated state, same lane packing as in_state.
- out_inv  out  1  in_inv of the beat currently at the output.
- out_valid  out  1  out_state holds a valid beat.
- out_ready  in  1  downstream accepts the beat this cycle.

Behaviour:
- Offset table r[x][y], rows listed as x=0..4 for each y:
  - y=0: 0, 1, 62, 28, 27
  - y=1: 36, 44, 6, 55, 20
  - y=2: 3, 10, 43, 25, 39
  - y=3: 41, 45, 15, 21, 8
  - y=4: 18, 2, 61, 56, 14
- Effective offset is r mod LANE_W, a compile-time constant per lane; no runtime barrel shifter.
- Forward mode: lane' = rotl(lane, off). Inverse mode: lane' = rotr(lane, off).
- Rotation logic is combinational on in_state/in_inv and feeds stage 0.
- Pipeline structure: stages 0..DEPTH-1, each holding data, inv and a valid bit v[k]. Stage DEPTH-1 drives the outputs.
- Ready chain: rdy[DEPTH-1] = ~v[DEPTH-1] | out_ready; rdy[k] = ~v[k] | rdy[k+1]; in_ready = rdy[0].
  - This is combinational, so bubbles collapse.
  - out_ready to in_ready is a combinational path; accepted.
- Transfers:
  - Stage k loads from stage k-1 (or the input for k=0) when rdy[k]=1.
  - v[k] <= v[k-1] (or in_valid for k=0).
  - Data registers load only when rdy[k]=1 and the upstream beat is valid; they hold otherwise.
- Latency: DEPTH cycles from the input handshake (in_valid & in_ready) to out_valid, with no stall.
- Throughput: 1 beat per cycle while out_ready=1.
- Stalls:
  - With out_ready=0, out_state/out_inv/out_valid hold stable.
  - The pipeline accepts beats until all DEPTH stages are full, then in_ready=0.
  - Dropping in_valid while in_ready=0 is legal; there is no ordering requirement on the upstream.
- Simultaneous events: with a full pipe and out_ready=1, in_ready=1, and one beat leaves while one enters in the same cycle. No loss, no duplication.
- Ordering: beats exit strictly in acceptance order, each with its own inv flag.
- Reset:
  - All v[k]=0, data=0, inv=0, so out_valid=0, out_state=0, out_inv=0.
  - in_ready=1 during and after reset (chain evaluates to 1 when empty).
  - Reset mid-stream discards all in-flight beats; the first beat after reset is treated normally.
- LANE_W=8 example: offset 62 becomes 6, 36 becomes 4, 0 stays 0 (lane (0,0) passes unmodified).

Test Plan:
- LANE_W=64, DEPTH=1, forward, all lanes=1 -> after 1 cycle, lane(1,0)=0x2, lane(2,0)=0x4000000000000000, lane(0,0)=0x1, lane(4,4)=0x4000; out_valid high for exactly 1 cycle.
- LANE_W=32, forward, lane(2,0)=0x1, lane(0,1)=0x80000000 -> lane(2,0)=0x40000000 (offset 30), lane(0,1)=0x00000008 (offset 4); inverse mode on those outputs restores 0x1 and 0x80000000.
- LANE_W=64, DEPTH=3, 10 back-to-back random beats with out_ready=1 -> out_valid first at cycle 3 after the first handshake, 10 consecutive valid beats, each equal to the golden-model rho; then fwd(x) fed through inv returns x.
- DEPTH=2, out_ready=0 while in_valid=1 held -> exactly 2 beats accepted, in_ready=0 from the third cycle, out_state stable; then out_ready=1 -> beats drain in order with no duplicate and no drop; in_ready=1 in the same cycle.
- DEPTH=3, out_ready toggled randomly, in_valid random, 1000 beats -> scoreboard matches count, order and per-beat inv; out_state never changes while out_valid=1 & out_ready=0.
- rst asserted for 1 cycle with 3 beats in flight (DEPTH=4) -> next cycle out_valid=0, out_state=0, in_ready=1; a new beat emerges after exactly 4 cycles, and no pre-reset beat ever appears.
